// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the ysyx_220066 divide/remainder sequencer:
// divider op codes, ALU control constants, FSM states and fixup kinds.
package ysyx_220066_pkg;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'd0,
      DIV_OP_DIVU = 2'd1,
      DIV_OP_REM  = 2'd2,
      DIV_OP_REMU = 2'd3
   } div_op_e;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b01000;

   typedef enum logic [2:0] {
      DIV_IDLE,
      DIV_PREP,
      DIV_ITER,
      DIV_FIX,
      DIV_DONE
   } div_state_e;

   // Which result the fixup stage should produce.
   typedef enum logic [1:0] {
      FIX_NORMAL,
      FIX_DIV_ZERO,
      FIX_OVERFLOW
   } fix_kind_e;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/ysyx_220066_div_fix.sv
// Combinational result fixup: applies quotient/remainder sign correction,
// substitutes the divide-by-zero and signed-overflow results, and
// sign-extends bit 31 for the W forms.
module ysyx_220066_div_fix
   import ysyx_220066_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  div_op_e         op,
   input  logic            word,
   input  fix_kind_e       kind,
   input  logic            neg_quot,
   input  logic            neg_rem,
   input  logic [XLEN-1:0] quot,
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] a_ext,
   output logic [XLEN-1:0] result
);

   localparam int HALF = XLEN / 2;

   logic [XLEN-1:0] q_val;
   logic [XLEN-1:0] r_val;
   logic [XLEN-1:0] sel;

   // Select the architectural quotient/remainder and narrow W results.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      q_val = neg_quot ? ('0 - quot) : quot;
      r_val = neg_rem  ? ('0 - rem)  : rem;
      case (kind)
         FIX_DIV_ZERO: begin
            q_val = '1;
            r_val = a_ext;
         end
         FIX_OVERFLOW: begin
            // The dividend already is the minimum value at the operand width.
            q_val = a_ext;
            r_val = '0;
         end
         default: ;
      endcase
      sel    = op_is_rem(op) ? r_val : q_val;
      result = word ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
   end

endmodule

// File: rtl/ysyx_220066_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per ITER cycle, using the shared ALU as a subtractor.
// Optional feature macro: YSYX_220066_DIV_FLUSH_EN adds a 'flush' input
// that aborts any operation back to IDLE.
module ysyx_220066_div_seq
   import ysyx_220066_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            busy,
`ifdef YSYX_220066_DIV_FLUSH_EN
   input  logic            flush,
`endif
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [4:0]      alu_ctr,
   input  logic [XLEN-1:0] alu_result
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN) + 1;

   div_state_e      state_q, state_d;
   div_op_e         op_q;
   logic            word_q;
   logic [XLEN-1:0] a_q, b_q;
   logic [XLEN-1:0] rem_q, quot_q, bmag_q;
   logic [XLEN-1:0] out_data_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_quot_q, neg_rem_q;

   logic            flush_en;
   logic            signed_op;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
   logic            a_neg, b_neg, div_zero, sgn_ovf, special;
   fix_kind_e       fix_kind;
   logic [XLEN-1:0] fix_result;
   logic            rem_ovf, borrow, take;
   logic [XLEN-1:0] rem_sh;

`ifdef YSYX_220066_DIV_FLUSH_EN
   assign flush_en = flush;
`else
   assign flush_en = 1'b0;
`endif

   // Operand preparation: width extension, magnitudes and special-case detection.
   always_comb begin
      signed_op = op_is_signed(op_q);
      a_ext     = word_q ? {{HALF{signed_op & a_q[HALF-1]}}, a_q[HALF-1:0]} : a_q;
      b_ext     = word_q ? {{HALF{signed_op & b_q[HALF-1]}}, b_q[HALF-1:0]} : b_q;
      a_neg     = signed_op & a_ext[XLEN-1];
      b_neg     = signed_op & b_ext[XLEN-1];
      a_mag     = a_neg ? ('0 - a_ext) : a_ext;
      b_mag     = b_neg ? ('0 - b_ext) : b_ext;
      min_val   = word_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                         : {1'b1, {(XLEN-1){1'b0}}};
      div_zero  = (b_ext == '0);
      sgn_ovf   = signed_op & (a_ext == min_val) & (&b_ext);
      special   = div_zero | sgn_ovf;
      fix_kind  = FIX_NORMAL;
      if (state_q == DIV_PREP) begin
         if (div_zero)     fix_kind = FIX_DIV_ZERO;
         else if (sgn_ovf) fix_kind = FIX_OVERFLOW;
      end
   end

   // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
   always_comb begin
      rem_ovf = rem_q[XLEN-1];
      rem_sh  = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
      alu_a   = rem_sh;
      alu_b   = bmag_q;
      borrow  = (~alu_a[XLEN-1] & alu_b[XLEN-1])
              | (~(alu_a[XLEN-1] ^ alu_b[XLEN-1]) & alu_result[XLEN-1]);
      // A bit shifted out of the remainder means it already exceeds the divisor.
      take    = rem_ovf | ~borrow;
   end

   ysyx_220066_div_fix #(.XLEN(XLEN)) u_fix (
      .op       (op_q),
      .word     (word_q),
      .kind     (fix_kind),
      .neg_quot (neg_quot_q),
      .neg_rem  (neg_rem_q),
      .quot     (quot_q),
      .rem      (rem_q),
      .a_ext    (a_ext),
      .result   (fix_result)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state_q <= DIV_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake/ALU control decode.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      alu_ctr   = ALU_ADD;
      unique case (state_q)
         DIV_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = DIV_PREP;
         end
         DIV_PREP: state_d = special ? DIV_DONE : DIV_ITER;
         DIV_ITER: begin
            alu_ctr = ALU_SUB;
            if (cnt_q == CW'(1)) state_d = DIV_FIX;
         end
         DIV_FIX:  state_d = DIV_DONE;
         DIV_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = DIV_IDLE;
         end
         default:  state_d = DIV_IDLE;
      endcase
      if (flush_en) state_d = DIV_IDLE;
   end

   // Datapath registers: request latch, shift registers, counter and result.
   always_ff @(posedge clk) begin
      // NOTE: the datapath is small and fully reset so out_data and the counter read 0 after reset.
      if (rst) begin
         op_q       <= DIV_OP_DIV;
         word_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         bmag_q     <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (in_valid && !flush_en) begin
                  op_q   <= div_op_e'(in_op);
                  word_q <= in_word;
                  a_q    <= in_a;
                  b_q    <= in_b;
               end
            end
            DIV_PREP: begin
               rem_q      <= '0;
               // W forms left-align the 32-bit magnitude so 32 steps consume it.
               quot_q     <= word_q ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
               bmag_q     <= b_mag;
               neg_quot_q <= a_neg ^ b_neg;
               neg_rem_q  <= a_neg;
               cnt_q      <= word_q ? CW'(HALF) : CW'(XLEN);
               if (special) out_data_q <= fix_result;
            end
            DIV_ITER: begin
               rem_q  <= take ? alu_result : rem_sh;
               quot_q <= {quot_q[XLEN-2:0], take};
               cnt_q  <= cnt_q - CW'(1);
            end
            DIV_FIX:  out_data_q <= fix_result;
            default: ;
         endcase
      end
   end

   assign out_data = out_data_q;

endmodule

// File: tb/tb_ysyx_220066_div_seq.sv
// Self-checking bench for ysyx_220066_div_seq: directed vector table,
// hand-written multi-cycle sequences and randomized operations against
// an arithmetic reference model. The ALU is modelled beside the DUT.
module tb_ysyx_220066_div_seq;
   import ysyx_220066_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'd0;
   logic        in_word = 1'b0;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        busy;
   logic [63:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_ctr;
`ifdef YSYX_220066_DIV_FLUSH_EN
   logic        flush = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Shared ALU: combinational add/sub.
   always_comb alu_result = (alu_ctr == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

   ysyx_220066_div_seq #(.XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_word    (in_word),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
`ifdef YSYX_220066_DIV_FLUSH_EN
      .flush      (flush),
`endif
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctr    (alu_ctr),
      .alu_result (alu_result)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] sext32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

   // Reference: RISC-V M-extension divide semantics with plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic is_signed, is_rem;
      logic [63:0] q, r;
      is_signed = (op == 2'd0) || (op == 2'd2);
      is_rem    = op[1];
      if (w) begin
         logic signed [31:0] sa, sb;
         logic [31:0] ua, ub, q32, r32;
         ua = a[31:0]; ub = b[31:0]; sa = ua; sb = ub;
         if (ub == 32'd0) begin
            q32 = '1; r32 = ua;
         end else if (is_signed && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
            q32 = ua; r32 = '0;
         end else if (is_signed) begin
            q32 = sa / sb; r32 = sa % sb;
         end else begin
            q32 = ua / ub; r32 = ua % ub;
         end
         q = sext32(q32); r = sext32(r32);
      end else begin
         logic signed [63:0] sa, sb;
         sa = a; sb = b;
         if (b == 64'd0) begin
            q = '1; r = a;
         end else if (is_signed && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = '0;
         end else if (is_signed) begin
            q = sa / sb; r = sa % sb;
         end else begin
            q = a / b; r = a % b;
         end
      end
      return is_rem ? r : q;
   endfunction

   // Edges from the accepting edge to out_valid: special cases go PREP->DONE.
   function automatic int ref_lat(input logic [1:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic is_signed, zero, ovf;
      is_signed = (op == 2'd0) || (op == 2'd2);
      zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf  = is_signed && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == '1));
      if (zero || ovf) return 1;
      return w ? 34 : 66;
   endfunction

   // Issue one request, wait (bounded) for the result, then accept it.
   task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] data,
                         output int lat, output logic ok);
      ok = 1'b0; lat = 0; data = '0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b;
      @(posedge clk); #1;
      @(negedge clk);
      in_valid = 1'b0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      data = out_data;
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); out_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [63:0] data, held, a, b, exp;
      logic [1:0]  op;
      logic        w, ok, stable, seen;
      int          lat;

      vecs[0]  = '{2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 66};
      vecs[1]  = '{2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 66};
      vecs[2]  = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
      vecs[3]  = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      vecs[4]  = '{2'd2, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
      vecs[5]  = '{2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      vecs[6]  = '{2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      vecs[7]  = '{2'd1, 1'b0, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[8]  = '{2'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1};
      vecs[9]  = '{2'd1, 1'b1, 64'h1_0000_0005, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[10] = '{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 66};
      vecs[11] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      vecs[12] = '{2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34};
      vecs[13] = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34};
      vecs[14] = '{2'd3, 1'b1, 64'h1_0000_0064, 64'd7, 64'd2, 34};
      vecs[15] = '{2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 66};

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset out_data", out_data, 0);
      check("reset alu_ctr", alu_ctr, 0);

      // Directed vectors.
      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, data, lat, ok);
         check($sformatf("vec%0d timeout", i), ok, 1);
         check($sformatf("vec%0d data", i), data, vecs[i].exp);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      end

      // Back-pressure and in_valid while busy.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_a = 64'd1000; in_b = 64'd3;
      @(posedge clk); #1;
      @(negedge clk); in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy in_ready", in_ready, 0);
      check("busy flag", busy, 1);
      check("iter alu_ctr", alu_ctr, ALU_SUB);
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd2; in_a = 64'd77; in_b = 64'd5;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      lat = 0; ok = 1'b0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("bp timeout", ok, 1);
      check("bp data", out_data, 64'd333);
      held = out_data;
      stable = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
      end
      check("bp held", stable, 1);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp out_valid dropped", out_valid, 0);
      check("bp in_ready", in_ready, 1);
      @(negedge clk); out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no queued op", busy, 0);

      // Reset in the middle of ITER.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd0; in_word = 1'b0; in_a = 64'd999; in_b = 64'd10;
      @(posedge clk); #1;
      @(negedge clk); in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("rst no result", seen, 0);
      run_op(2'd0, 1'b0, 64'd999, 64'd10, data, lat, ok);
      check("post-rst data", data, 64'd99);

`ifdef YSYX_220066_DIV_FLUSH_EN
      // Flush at ITER cycle 5, then a clean request.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_a = 64'd500; in_b = 64'd9;
      @(posedge clk); #1;
      @(negedge clk); in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      check("flush in_ready", in_ready, 1);
      check("flush out_valid", out_valid, 0);
      @(negedge clk); flush = 1'b0;
      run_op(2'd3, 1'b0, 64'd500, 64'd9, data, lat, ok);
      check("post-flush data", data, 64'd5);
      check("post-flush latency", lat, 66);
`endif

      // Randomized operations against the reference model.
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         case ($urandom_range(0, 9))
            0:       b = 64'd0;
            1:       b = '1;
            2, 3, 4: b = 64'($urandom_range(1, 20));
            default: b = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 7) == 0) a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
         exp = ref_result(op, w, a, b);
         run_op(op, w, a, b, data, lat, ok);
         check($sformatf("rand%0d timeout", i), ok, 1);
         check($sformatf("rand%0d op%0d w%0d a=%h b=%h", i, op, w, a, b), data, exp);
         check($sformatf("rand%0d latency", i), lat, ref_lat(op, w, a, b));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
